// File: rtl/axis_pha_acq_controller.sv
// ---------------------------------------------------------------------------
// axis_pha_acq_controller
//
// Runs one spectrum acquisition around a pulse height analyzer:
//   IDLE  -> waits for a cfg_start rising edge
//   CLEAR -> optionally writes zero to every histogram BRAM word, one per cycle
//   RUN   -> releases the analyzer from reset and passes its events through
//            to the histogrammer, counting cycles and accepted events
//   DONE  -> holds the status counters until the next start edge
// A run stops on the live-time limit, the event-count limit or cfg_stop.
//
// Ports
//   aclk, aresetn                 clock, asynchronous active-low reset
//   cfg_start/stop/clear          control levels from the PS
//   cfg_time, cfg_count           run limits (0 = unlimited)
//   pha_aresetn                   analyzer reset, high only during RUN
//   s_axis_*                      event stream from the analyzer
//   m_axis_*                      gated event stream to the histogrammer
//   bram_porta_*                  histogram BRAM port used for clearing
//   sts_state, sts_time, sts_count  status back to the PS
// ---------------------------------------------------------------------------
module axis_pha_acq_controller #(
  parameter int AXIS_TDATA_WIDTH = 16,
  parameter int TIME_WIDTH       = 32,
  parameter int EVNT_WIDTH       = 32,
  parameter int BRAM_ADDR_WIDTH  = 14,
  parameter int BRAM_DATA_WIDTH  = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,

  input  logic                        cfg_start,
  input  logic                        cfg_stop,
  input  logic                        cfg_clear,
  input  logic [TIME_WIDTH-1:0]       cfg_time,
  input  logic [EVNT_WIDTH-1:0]       cfg_count,

  output logic                        pha_aresetn,

  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,

  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,

  output logic                        bram_porta_clk,
  output logic                        bram_porta_rst,
  output logic [BRAM_ADDR_WIDTH-1:0]  bram_porta_addr,
  output logic [BRAM_DATA_WIDTH-1:0]  bram_porta_wrdata,
  output logic                        bram_porta_we,

  output logic [1:0]                  sts_state,
  output logic [TIME_WIDTH-1:0]       sts_time,
  output logic [EVNT_WIDTH-1:0]       sts_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                      r_state;
  state_t                      w_next_state;

  logic                        r_start_d;
  logic                        r_pha_aresetn;
  logic [TIME_WIDTH-1:0]       r_time;
  logic [EVNT_WIDTH-1:0]       r_count;
  logic [BRAM_ADDR_WIDTH-1:0]  r_addr;

  logic                        w_start_ok;
  logic                        w_xfer;
  logic                        w_terminal;
  logic                        w_addr_last;
  logic [TIME_WIDTH-1:0]       w_time_inc;
  logic [EVNT_WIDTH-1:0]       w_count_inc;

  // A start is honoured only from IDLE/DONE and never while an abort is held.
  assign w_start_ok  = cfg_start & ~r_start_d & ~cfg_stop &
                       ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_xfer      = s_axis_tvalid & m_axis_tready;
  assign w_addr_last = (r_addr == {BRAM_ADDR_WIDTH{1'b1}});
  assign w_time_inc  = r_time + TIME_WIDTH'(1);
  assign w_count_inc = r_count + EVNT_WIDTH'(1);

  // The current cycle is the last RUN cycle; its transfer and tick still count.
  assign w_terminal  = ((cfg_time != '0) && (w_time_inc == cfg_time)) ||
                       ((cfg_count != '0) && w_xfer && (w_count_inc == cfg_count)) ||
                       cfg_stop;

  // ---------------- state register ----------------
  // NOTE: all clocked state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // ---------------- next-state logic ----------------
  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (w_start_ok) w_next_state = cfg_clear ? ST_CLEAR : ST_RUN;
      ST_CLEAR: begin
        if (cfg_stop)         w_next_state = ST_IDLE;
        else if (w_addr_last) w_next_state = ST_RUN;
      end
      ST_RUN:   if (w_terminal) w_next_state = ST_DONE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // ---------------- outputs ----------------
  always_comb begin
    m_axis_tvalid = 1'b0;
    s_axis_tready = 1'b1;  // drain stale analyzer output outside RUN
    bram_porta_we = 1'b0;
    case (r_state)
      ST_RUN: begin
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
      end
      ST_CLEAR: bram_porta_we = ~cfg_stop;  // abort drops the write at once
      default: ;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_start_d     <= 1'b0;
      r_pha_aresetn <= 1'b0;
      r_time        <= '0;
      r_count       <= '0;
      r_addr        <= '0;
    end else begin
      r_start_d     <= cfg_start;
      // Registered from the next state so the analyzer reset is glitch-free
      // and releases exactly on the first RUN cycle.
      r_pha_aresetn <= (w_next_state == ST_RUN);

      if (w_start_ok) begin
        r_time  <= '0;
        r_count <= '0;
      end else if (r_state == ST_RUN) begin
        r_time <= w_time_inc;
        if (w_xfer && (r_count != {EVNT_WIDTH{1'b1}})) r_count <= w_count_inc;
      end

      // Address wraps to 0 after the last word, ready for the next clear.
      if ((r_state == ST_CLEAR) && !cfg_stop) r_addr <= r_addr + BRAM_ADDR_WIDTH'(1);
      else                                    r_addr <= '0;
    end
  end

  assign pha_aresetn       = r_pha_aresetn;
  assign m_axis_tdata      = s_axis_tdata;
  assign bram_porta_clk    = aclk;
  assign bram_porta_rst    = ~aresetn;
  assign bram_porta_addr   = r_addr;
  assign bram_porta_wrdata = '0;
  assign sts_state         = r_state;
  assign sts_time          = r_time;
  assign sts_count         = r_count;

endmodule

// File: tb/tb_axis_pha_acq_controller.sv
// ---------------------------------------------------------------------------
// tb_axis_pha_acq_controller
//
// Directed bench for axis_pha_acq_controller with a 16-word histogram.
// Inputs are driven 1 ns after each rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_axis_pha_acq_controller;

  localparam int DW = 16;
  localparam int TW = 32;
  localparam int EW = 32;
  localparam int AW = 4;
  localparam int BW = 32;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          cfg_start, cfg_stop, cfg_clear;
  logic [TW-1:0] cfg_time;
  logic [EW-1:0] cfg_count;
  logic          pha_aresetn;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          bram_porta_clk, bram_porta_rst, bram_porta_we;
  logic [AW-1:0] bram_porta_addr;
  logic [BW-1:0] bram_porta_wrdata;
  logic [1:0]    sts_state;
  logic [TW-1:0] sts_time;
  logic [EW-1:0] sts_count;

  int n_checks = 0;
  int n_pass   = 0;

  axis_pha_acq_controller #(
    .AXIS_TDATA_WIDTH(DW), .TIME_WIDTH(TW), .EVNT_WIDTH(EW),
    .BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(BW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_clear(cfg_clear),
    .cfg_time(cfg_time), .cfg_count(cfg_count),
    .pha_aresetn(pha_aresetn),
    .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .bram_porta_clk(bram_porta_clk), .bram_porta_rst(bram_porta_rst),
    .bram_porta_addr(bram_porta_addr), .bram_porta_wrdata(bram_porta_wrdata),
    .bram_porta_we(bram_porta_we),
    .sts_state(sts_state), .sts_time(sts_time), .sts_count(sts_count)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  int n;

  initial begin
    aresetn = 1'b0;
    cfg_start = 1'b0; cfg_stop = 1'b0; cfg_clear = 1'b0;
    cfg_time = '0; cfg_count = '0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
    #2;
    // ---- reset state ----
    check("rst_state",  sts_state, 0);
    check("rst_pha",    pha_aresetn, 0);
    check("rst_we",     bram_porta_we, 0);
    check("rst_time",   sts_time, 0);
    check("rst_count",  sts_count, 0);
    check("rst_tready", s_axis_tready, 1);
    check("rst_bramrst", bram_porta_rst, 1);
    tick(); tick();
    aresetn = 1'b1;
    tick();

    // ---- clear sweep of 16 words, then RUN ----
    cfg_clear = 1'b1; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("clr_state", sts_state, 1);
      check("clr_we",    bram_porta_we, 1);
      check("clr_addr",  bram_porta_addr, i);
      check("clr_data",  bram_porta_wrdata, 0);
      check("clr_pha",   pha_aresetn, 0);
      tick();
    end
    check("clr_to_run", sts_state, 2);
    check("clr_pha_up", pha_aresetn, 1);
    check("clr_we_off", bram_porta_we, 0);
    // abort the unlimited run after one cycle
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    check("abort_done",  sts_state, 3);
    check("abort_time",  sts_time, 1);
    check("abort_pha",   pha_aresetn, 0);

    // ---- time-limited run, 100 cycles, continuous traffic ----
    cfg_clear = 1'b0; cfg_time = 100; cfg_count = 0;
    s_axis_tvalid = 1'b1; s_axis_tdata = 16'hA5C3; m_axis_tready = 1'b1;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("t3_run",     sts_state, 2);
    check("t3_zero_t",  sts_time, 0);
    check("t3_zero_c",  sts_count, 0);
    check("t3_mvalid",  m_axis_tvalid, 1);
    check("t3_mdata",   m_axis_tdata, 16'hA5C3);
    n = 0;
    while (sts_state == 2 && n < 300) begin
      cfg_start = (n == 50);  // start edge mid-run must be ignored
      m_axis_tready = 1'b1;
      tick();
      n++;
    end
    cfg_start = 1'b0;
    check("t3_cycles",  n, 100);
    check("t3_done",    sts_state, 3);
    check("t3_time",    sts_time, 100);
    check("t3_count",   sts_count, 100);
    check("t3_mvalid0", m_axis_tvalid, 0);
    m_axis_tready = 1'b0;
    #1;
    check("t3_tready1", s_axis_tready, 1);
    tick();
    check("t3_hold_t",  sts_time, 100);

    // ---- event-limited run, 5 handshakes, sparse traffic ----
    cfg_time = 0; cfg_count = 5;
    s_axis_tvalid = 1'b0;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("t4_run",    sts_state, 2);
    check("t4_zero_t", sts_time, 0);
    check("t4_zero_c", sts_count, 0);
    n = 0;
    // valid when n%3==0, tready when n%2==0: handshakes at n=0,6,12,18,24
    while (sts_state == 2 && n < 300) begin
      s_axis_tvalid = (n % 3 == 0);
      m_axis_tready = (n % 2 == 0);
      #1;
      check("t4_stready", s_axis_tready, (n % 2 == 0));
      tick();
      n++;
    end
    check("t4_cycles", n, 25);
    check("t4_done",   sts_state, 3);
    check("t4_count",  sts_count, 5);
    check("t4_time",   sts_time, 25);
    s_axis_tvalid = 1'b0;

    // ---- abort during CLEAR at address 7 ----
    cfg_count = 0; cfg_clear = 1'b1;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("t5_addr7", bram_porta_addr, 7);
    cfg_stop = 1'b1;
    tick();
    check("t5_idle",  sts_state, 0);
    check("t5_we0",   bram_porta_we, 0);
    check("t5_addr0", bram_porta_addr, 0);
    cfg_start = 1'b1;   // edge while stop is held
    tick(); tick();
    check("t5_stay",  sts_state, 0);
    cfg_start = 1'b0; cfg_stop = 1'b0;
    tick();

    // ---- async reset in the middle of RUN ----
    cfg_clear = 1'b0; s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    tick(); tick();
    check("t1_run", sts_state, 2);
    aresetn = 1'b0;
    #1;
    check("t1_state",  sts_state, 0);
    check("t1_pha",    pha_aresetn, 0);
    check("t1_mvalid", m_axis_tvalid, 0);
    tick();
    aresetn = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bram_porta_we !== 1'b0) n++;
    end
    check("t1_no_we",   n, 0);
    check("t1_idle",    sts_state, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_pha_acq_controller.md
Name: axis_pha_acq_controller

Overview:
- Sequences one spectrum acquisition around the pulse height analyzer.
- Optionally zeroes the histogram BRAM, then releases the analyzer from reset and gates its event stream through to the histogrammer.
- Stops on a live-time limit, an event-count limit or an abort, and reports elapsed cycles and accepted events to the PS via status registers.

Parameters:
AXIS_TDATA_WIDTH, 16, event (pulse height) word width
TIME_WIDTH, 32, run timer and cfg_time width
EVNT_WIDTH, 32, event counter and cfg_count width
BRAM_ADDR_WIDTH, 14, histogram BRAM address width
BRAM_DATA_WIDTH, 32, histogram BRAM word width

Ports:
aclk  in  1  system clock
aresetn  in  1  asynchronous active-low reset
cfg_start  in  1  level; a rising edge starts an acquisition
cfg_stop  in  1  level; abort while high
cfg_clear  in  1  sampled at start; 1 = zero histogram first
cfg_time  in  TIME_WIDTH  run length in aclk cycles; 0 = unlimited
cfg_count  in  EVNT_WIDTH  event limit; 0 = unlimited
pha_aresetn  out  1  reset to analyzer; 1 only in RUN
s_axis_tready  out  1  to analyzer output
s_axis_tdata  in  AXIS_TDATA_WIDTH  pulse height
s_axis_tvalid  in  1  event valid
m_axis_tready  in  1  from histogrammer
m_axis_tdata  out  AXIS_TDATA_WIDTH  gated pulse height
m_axis_tvalid  out  1  gated valid
bram_porta_clk  out  1  = aclk
bram_porta_rst  out  1  = ~aresetn
bram_porta_addr  out  BRAM_ADDR_WIDTH  clear address
bram_porta_wrdata  out  BRAM_DATA_WIDTH  constant 0
bram_porta_we  out  1  clear write enable
sts_state  out  2  0 IDLE, 1 CLEAR, 2 RUN, 3 DONE
sts_time  out  TIME_WIDTH  cycles spent in RUN
sts_count  out  EVNT_WIDTH  events accepted

Behaviour:
- Reset (async, aresetn low): state IDLE; start-edge register 0; timer, counter and clear address 0; pha_aresetn 0; bram_porta_we 0.
- Start edge is detected as cfg_start & ~cfg_start_d, where cfg_start_d is a registered copy of cfg_start. Edges are honoured only in IDLE and DONE; ignored in CLEAR and RUN.
- IDLE/DONE on start edge:
  - sts_time and sts_count zero on the next edge.
  - Next state is CLEAR if cfg_clear=1, otherwise RUN.
  - If cfg_stop is high on the same cycle, the start is ignored.
- CLEAR:
  - bram_porta_we=1, wrdata 0, addr 0..2^BRAM_ADDR_WIDTH-1, one word per cycle.
  - After writing the last address, the next cycle is RUN, so CLEAR lasts exactly 2^BRAM_ADDR_WIDTH cycles.
  - cfg_stop high → IDLE next cycle; we deasserts immediately; addr resets to 0.
- RUN:
  - pha_aresetn=1 (registered, so the analyzer leaves reset on the first RUN cycle).
  - Zero-latency combinational passthrough: m_axis_tdata=s_axis_tdata; m_axis_tvalid=s_axis_tvalid; s_axis_tready=m_axis_tready.
  - Timer +1 every RUN cycle. The counter increments on each s_axis_tvalid & m_axis_tready; it saturates at all-ones.
  - Terminal condition, evaluated each cycle:
    - (cfg_time≠0 and timer+1==cfg_time), or
    - (cfg_count≠0 and transfer and count+1==cfg_count), or
    - cfg_stop.
  - On the terminal condition, the current-cycle transfer is accepted and counted, the timer increments, and the next state is DONE.
  - With cfg_time=N and no other stop, RUN lasts exactly N cycles and sts_time=N.
  - Simultaneous terminal conditions: a single transition to DONE; counts as above.
- Outside RUN:
  - m_axis_tvalid=0.
  - s_axis_tready=1, draining any stale analyzer output.
  - pha_aresetn=0.
- DONE: sts_time and sts_count hold until the next start edge. The cfg_* inputs are sampled live, and a change during RUN takes effect on the next cycle.
- Widths: all comparisons unsigned. No wrap of the timer within RUN is required when cfg_time≠0; with unlimited time the timer wraps modulo 2^TIME_WIDTH.

Test Plan:
1. Reset mid-RUN (aresetn low 1 cycle) → immediately sts_state=0, pha_aresetn=0, m_axis_tvalid=0; no BRAM writes afterwards.
2. BRAM_ADDR_WIDTH=4, cfg_clear=1, start edge → we high 16 cycles with addr 0..15 and wrdata 0, then sts_state=2 and pha_aresetn=1 on the next cycle.
3. cfg_clear=0, cfg_time=100, cfg_count=0, continuous valid with tready=1 → DONE after exactly 100 RUN cycles; sts_time=100, sts_count=100; m_axis_tvalid=0 in DONE.
4. cfg_time=0, cfg_count=5, valid every 3rd cycle with tready toggling → DONE on the cycle after the 5th handshake; sts_count=5; unhandshaken valids are not counted.
5. cfg_stop asserted in CLEAR at addr 7 → IDLE next cycle, we=0; a start edge with cfg_stop still high → remains IDLE.
6. Start edge during RUN → ignored. After DONE, a second start edge → sts_time/sts_count zeroed and a new run begins.
